rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Two-port arbiter that shares the single-ported instruction ROM between the core's instruction-fetch port (port 0) and its data-load port (port 1).
- Serialises word reads onto the ROM re/addr/data/oe interface.
- Waits a configurable latency and checks the oe qualifier before returning data to the winning port.
- Arbitration is round-robin; a timeout returns an error instead of hanging the core.

Parameters:
- MEM_LATENCY, 1, cycles after the mem_re cycle before mem_rdata may be sampled (1 matches a zero-delay ROM); legal range 1..15.
- TIMEOUT, 15, cycles after mem_re after which the transaction aborts with error; must be > MEM_LATENCY and ≤ 15.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  port request; held high with a stable address until that port's rvalid.
- addr0 / addr1  in  32  byte address (word-aligned; bits [1:0] are ignored).
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse: response is valid.
- rdata0 / rdata1  out  32  response data, held until the next response on that port.
- rerr0 / rerr1  out  1  timeout flag, qualified by rvalid.
- mem_re  out  1  ROM read enable, one-cycle pulse.
- mem_addr  out  32  ROM byte address, held stable from mem_re through capture.
- mem_rdata  in  32  ROM data.
- mem_oe  in  1  ROM output-valid qualifier.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state): state=IDLE; all gnt, rvalid, rerr and mem_re = 0; rdata0/1 = 0; mem_addr = 0; wait counter = 0; last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - A port is eligible when its req=1 and its rvalid is not asserted this cycle; this prevents a duplicate grant on the response cycle.
  - No eligible port: stay in IDLE.
  - One eligible port: select it.
  - Both eligible: select the port that is not last_grant.
  - On selection, in the next cycle: gnt<sel>=1, mem_re=1, mem_addr={addr<sel>[31:2],2'b00}; set last_grant=sel; go to ISSUE.
- ISSUE: lasts exactly one cycle (mem_re high); mem_re drops next cycle; counter=1; go to WAIT.
- WAIT:
  - Counter increments each cycle, saturating at TIMEOUT.
  - If counter ≥ MEM_LATENCY and mem_oe=1: capture mem_rdata into rdata<sel>; next cycle rvalid<sel>=1 and rerr<sel>=0; go to IDLE.
  - Else if counter == TIMEOUT: next cycle rvalid<sel>=1, rerr<sel>=1, rdata<sel>=0; go to IDLE.
  - mem_oe=0 at or after MEM_LATENCY extends WAIT without error until TIMEOUT.
- Latency (MEM_LATENCY=1, mem_oe high):
  - req seen in IDLE at cycle 0; gnt/mem_re at cycle 1; capture at end of cycle 2; rvalid at cycle 3.
  - 3-cycle minimum latency. Back-to-back throughput is one word per 3 cycles, because the IDLE decision overlaps the rvalid cycle.
- Only one transaction is outstanding at a time. The other port's req is ignored until IDLE.
- Requests arriving during ISSUE or WAIT are not lost; they are arbitrated at the next IDLE.
- If req drops during WAIT (protocol violation), the transaction still completes and rvalid still pulses.
- gnt and rvalid never assert for both ports in the same cycle.
- Reset asserted mid-transaction: abort immediately; no rvalid is produced after reset release. mem_re deasserts asynchronously.
- rdata of the non-selected port is never modified.

Test Plan:
- Single fetch: req0=1, addr0=0x0000_0008, mem_rdata=0xDEAD_BEEF, mem_oe=1 → gnt0 at cycle 1 with mem_addr=0x8; rvalid0 at cycle 3 with rdata0=0xDEAD_BEEF, rerr0=0.
- Contention: req0 and req1 both held for 4 transactions (addr0=0x10, addr1=0x20) → grant order 0,1,0,1; mem_addr alternates 0x10/0x20; rvalid pulses spaced 3 cycles apart, never both in one cycle.
- Slow memory: MEM_LATENCY=1, mem_oe held low for 3 cycles after mem_re, then high with data 0x1234_5678 → rvalid at cycle 6, rdata=0x1234_5678, rerr=0.
- Timeout: TIMEOUT=4, mem_oe stuck at 0 → rvalid1 at cycle 6 with rerr1=1, rdata1=0; the next req1 is granted normally.
- Misaligned address: addr1=0x0000_0013 → mem_addr=0x0000_0010.
- Reset mid-WAIT: drop rst_n in cycle 2 of a port-0 read, release after 2 cycles → all outputs 0 during reset; no rvalid0 afterwards; with req1 and req0 both held, port 0 is granted first.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one single-ported ROM between fetch (port 0) and load (port 1),
// with configurable read latency, an output-valid qualifier and a timeout that returns an error response.
module rom_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        rerr0,
  output logic        rerr1,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_oe
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [3:0] TMO = 4'(TIMEOUT);
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       rerr_q, rerr_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic             mem_re_q, mem_re_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [1:0]       elig;
  logic             pick;
  logic [31:0]      pick_addr;
  // a port whose response is on the outputs this cycle sits out, so it cannot be granted twice
  assign elig      = {req1 & ~rvalid_q[1], req0 & ~rvalid_q[0]};
  assign pick      = (&elig) ? ~last_q : elig[1];
  assign pick_addr = pick ? addr1 : addr0;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rerr_d     = rerr_q;
    rdata_d    = rdata_q;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (|elig) begin
        sel_d      = pick;
        last_d     = pick;
        gnt_d      = pick ? 2'b10 : 2'b01;
        mem_re_d   = 1'b1;
        mem_addr_d = pick_addr & ~32'h3;
        state_d    = ISSUE;
      end
      ISSUE: begin
        cnt_d   = 4'd1;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + 4'd1;
        if (cnt_q >= LAT && mem_oe) begin
          rdata_d[sel_q]  = mem_rdata;
          rvalid_d[sel_q] = 1'b1;
          rerr_d[sel_q]   = 1'b0;
          state_d         = IDLE;
        end else if (cnt_q == TMO) begin
          rdata_d[sel_q]  = '0;
          rvalid_d[sel_q] = 1'b1;
          rerr_d[sel_q]   = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rerr_q     <= '0;
      rdata_q    <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      rdata_q    <= rdata_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
    end
  end
  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign rerr0    = rerr_q[0];
  assign rerr1    = rerr_q[1];
  assign rdata0   = rdata_q[0];
  assign rdata1   = rdata_q[1];
  assign mem_re   = mem_re_q;
  assign mem_addr = mem_addr_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scenarios plus a randomized run scored against a transaction-schedule model.
module tb_rom_arbiter;
  localparam int ML  = 1;
  localparam int TMO = 4;
  localparam int N   = 800;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, mem_re, mem_oe;
  logic [31:0] rdata0, rdata1, mem_addr, mem_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;
  // model: per-cycle scheduled events, derived from grant time and the pre-drawn oe/data streams
  logic [1:0]  ev_g  [N+20];
  logic [1:0]  ev_rv [N+20];
  logic        ev_e  [N+20];
  logic [31:0] ev_d  [N+20];
  logic [31:0] ev_a  [N+20];
  logic        oe_at [N+20];
  logic [31:0] rd_at [N+20];
  logic [31:0] c_addr;
  logic [31:0] c_rd [2];
  logic [1:0]  rq, elig;
  logic [31:0] ad [2];
  logic        last, sel, found;
  int          free_at, g, r;
  rom_arbiter #(.MEM_LATENCY(ML), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .rerr0(rerr0), .rerr1(rerr1),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_oe(mem_oe)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'd0);
    check({tag, "_rvalid"}, 32'({rvalid1, rvalid0}), 32'd0);
    check({tag, "_rerr"}, 32'({rerr1, rerr0}), 32'd0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_rdata0"}, rdata0, 32'd0);
    check({tag, "_rdata1"}, rdata1, 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; mem_rdata = '0; mem_oe = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    // single fetch
    req0 = 1'b1; addr0 = 32'h8; mem_rdata = 32'hDEAD_BEEF; mem_oe = 1'b1;
    tick();
    check("fetch_gnt", 32'({gnt1, gnt0}), 32'd1);
    check("fetch_mem_re", 32'(mem_re), 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h8);
    tick();
    check("fetch_early_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    tick();
    check("fetch_rvalid", 32'({rvalid1, rvalid0}), 32'd1);
    check("fetch_rdata0", rdata0, 32'hDEAD_BEEF);
    check("fetch_rerr0", 32'(rerr0), 32'd0);
    req0 = 1'b0;
    // misaligned address on port 1
    req1 = 1'b1; addr1 = 32'h13;
    tick();
    check("misal_gnt", 32'({gnt1, gnt0}), 32'd2);
    check("misal_mem_addr", mem_addr, 32'h10);
    repeat (2) tick();
    check("misal_rvalid", 32'({rvalid1, rvalid0}), 32'd2);
    check("misal_rdata1", rdata1, 32'hDEAD_BEEF);
    // contention: four back-to-back transactions alternate ports
    req0 = 1'b1; addr0 = 32'h10; req1 = 1'b1; addr1 = 32'h20; mem_rdata = 32'hC000_0000;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("cont_gnt", 32'({gnt1, gnt0}), (c % 3 == 1) ? (((c / 3) % 2 == 1) ? 32'd2 : 32'd1) : 32'd0);
      check("cont_rvalid", 32'({rvalid1, rvalid0}), (c % 3 == 0) ? ((((c / 3) - 1) % 2 == 1) ? 32'd2 : 32'd1) : 32'd0);
      if (c % 3 == 1) check("cont_mem_addr", mem_addr, ((c / 3) % 2 == 1) ? 32'h20 : 32'h10);
      if (c % 3 == 0) check("cont_rdata", (((c / 3) - 1) % 2 == 1) ? rdata1 : rdata0, 32'hC000_0000 + 32'(c - 1));
      mem_rdata = 32'hC000_0000 + 32'(c);
      if (c == 12) begin req0 = 1'b0; req1 = 1'b0; end
    end
    // slow memory: oe low for three cycles after mem_re
    req0 = 1'b1; addr0 = 32'h40; mem_oe = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) check("slow_gnt", 32'({gnt1, gnt0}), 32'd1);
      if (c >= 2 && c <= 5) check("slow_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      if (c == 5) begin mem_oe = 1'b1; mem_rdata = 32'h1234_5678; end
      if (c == 6) begin
        check("slow_rvalid", 32'({rvalid1, rvalid0}), 32'd1);
        check("slow_rdata0", rdata0, 32'h1234_5678);
        check("slow_rerr0", 32'(rerr0), 32'd0);
        req0 = 1'b0; mem_oe = 1'b0;
      end
    end
    // timeout with oe stuck low, then a normal retry on the same port
    req1 = 1'b1; addr1 = 32'h50; mem_oe = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) check("tmo_gnt", 32'({gnt1, gnt0}), 32'd2);
      if (c >= 2 && c <= 5) check("tmo_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      if (c == 6) begin
        check("tmo_rvalid", 32'({rvalid1, rvalid0}), 32'd2);
        check("tmo_rerr1", 32'(rerr1), 32'd1);
        check("tmo_rdata1", rdata1, 32'd0);
        check("tmo_rdata0_kept", rdata0, 32'h1234_5678);
      end
      if (c == 7) check("tmo_no_dup_gnt", 32'({gnt1, gnt0}), 32'd0);
      if (c == 8) begin
        check("retry_gnt", 32'({gnt1, gnt0}), 32'd2);
        mem_oe = 1'b1; mem_rdata = 32'h0BAD_F00D;
      end
      if (c == 10) begin
        check("retry_rvalid", 32'({rvalid1, rvalid0}), 32'd2);
        check("retry_rerr1", 32'(rerr1), 32'd0);
        check("retry_rdata1", rdata1, 32'h0BAD_F00D);
        req1 = 1'b0; mem_oe = 1'b0;
      end
    end
    // reset in the middle of a port-0 wait
    req0 = 1'b1; addr0 = 32'h60; mem_oe = 1'b0;
    tick();
    check("rstw_gnt", 32'({gnt1, gnt0}), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("rstw_async");
    req1 = 1'b1; addr1 = 32'h70;
    repeat (2) tick();
    check_all_zero("rstw_held");
    rst_n = 1'b1; mem_oe = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    check("rstw_first_gnt", 32'({gnt1, gnt0}), 32'd1);
    check("rstw_mem_addr", mem_addr, 32'h60);
    tick();
    check("rstw_no_stale_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    tick();
    check("rstw_rvalid", 32'({rvalid1, rvalid0}), 32'd1);
    check("rstw_rdata0", rdata0, 32'h5555_AAAA);
    req0 = 1'b0; req1 = 1'b0; mem_oe = 1'b0;
    // randomized run against the schedule model
    for (int i = 0; i < N + 20; i++) begin
      ev_g[i] = '0; ev_rv[i] = '0; ev_e[i] = 1'b0; ev_d[i] = '0; ev_a[i] = '0;
      oe_at[i] = ($urandom % 5) < 2;
      rd_at[i] = $urandom;
    end
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    c_addr = '0; c_rd[0] = '0; c_rd[1] = '0; rq = '0; ad[0] = '0; ad[1] = '0;
    last = 1'b1; free_at = 0;
    for (int t = 0; t < N; t++) begin
      if (ev_g[t] != 2'b00) c_addr = ev_a[t];
      if (ev_rv[t] != 2'b00) c_rd[ev_rv[t][1]] = ev_d[t];
      check("rnd_gnt", 32'({gnt1, gnt0}), 32'(ev_g[t]));
      check("rnd_rvalid", 32'({rvalid1, rvalid0}), 32'(ev_rv[t]));
      check("rnd_mem_re", 32'(mem_re), 32'(ev_g[t] != 2'b00));
      check("rnd_mem_addr", mem_addr, c_addr);
      check("rnd_rdata0", rdata0, c_rd[0]);
      check("rnd_rdata1", rdata1, c_rd[1]);
      if (ev_rv[t][0]) check("rnd_rerr0", 32'(rerr0), 32'(ev_e[t]));
      if (ev_rv[t][1]) check("rnd_rerr1", 32'(rerr1), 32'(ev_e[t]));
      mem_oe = oe_at[t]; mem_rdata = rd_at[t];
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || ev_rv[t][p]) begin
          rq[p] = ($urandom % 2) == 1;
          ad[p] = $urandom;
        end
      end
      req0 = rq[0]; req1 = rq[1]; addr0 = ad[0]; addr1 = ad[1];
      elig = rq & ~ev_rv[t];
      if (t >= free_at && elig != 2'b00) begin
        sel = (elig == 2'b11) ? ~last : elig[1];
        last = sel;
        g = t + 1;
        ev_g[g] = sel ? 2'b10 : 2'b01;
        ev_a[g] = ad[sel] & ~32'h3;
        r = g + TMO + 1;
        found = 1'b0;
        for (int a = 1; a <= TMO; a++) begin
          if (!found && a >= ML && oe_at[g + a]) begin
            found = 1'b1;
            r = g + a + 1;
          end
        end
        ev_rv[r] = ev_g[g];
        ev_e[r] = ~found;
        ev_d[r] = found ? rd_at[r - 1] : 32'd0;
        free_at = r;
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
